// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and operation encodings for the serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference and borrow cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial subtractor; SERIAL_SUBTRACTOR_ADD_MODE_EN adds an op port selecting add
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e         state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d;
  logic [CW-1:0]  cnt_q;
  logic           c_q, c_d, sub, cell_b, cell_bin, diff, bout;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic op_q;
  assign sub = (op_q == OP_SUB);
`else
  assign sub = 1'b1;
`endif
  // Addition reuses the subtractor cell: a+b+c == a-~b-~c, with carry = ~borrow
  assign cell_b   = sub ? b_q[0] : ~b_q[0];
  assign cell_bin = sub ? c_q : ~c_q;
  assign c_d      = sub ? bout : ~bout;
  assign r_d      = (r_q >> 1) | (WIDTH'(diff) << (WIDTH - 1));
  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (cell_b),
    .bin  (cell_bin),
    .diff (diff),
    .bout (bout)
  );
  // Control FSM with registered busy/done/d; d is written only once the last bit is known
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_q    <= OP_SUB;
`endif
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            d       <= {c_d, r_d};
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            op_q    <= op;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors checked against an arithmetic reference model every cycle
module tb_serial_subtractor;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, start = 0, op = 1;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [W:0] d;
  int tests = 0, fails = 0;
  bit chk_en = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .d     (d)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    return o ? (W+1)'(x) - (W+1)'(y) : (W+1)'(x) + (W+1)'(y);
  endfunction

  // Reference model: an accepted start yields a result W cycles later; start is ignored meanwhile
  logic m_busy = 0, m_done = 0;
  logic [W:0] m_d = '0, pend = '0;
  int left = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_d <= '0; left <= 0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) begin
        m_busy <= 0; m_done <= 1; m_d <= pend;
      end
    end else begin
      m_done <= 0;
      if (start) begin
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        pend <= ref_result(a, b, op);
`else
        pend <= ref_result(a, b, 1'b1);
`endif
        left <= W; m_busy <= 1;
      end
    end
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("model_busy", (W+1)'(busy), (W+1)'(m_busy));
    check("model_done", (W+1)'(done), (W+1)'(m_done));
    check("model_d", d, m_d);
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    start = 1; a = x; b = y; op = o;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name, input logic [W:0] exp, input int exp_busy);
    int nb = 0;
    bit seen = 0;
    if (busy) nb++;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        if (busy) nb++;
      end
    end
    check({name, "_seen"}, (W+1)'(seen), (W+1)'(1));
    check({name, "_d"}, d, exp);
    if (exp_busy > 0) check({name, "_busy_cycles"}, (W+1)'(nb), (W+1)'(exp_busy));
  endtask

  initial begin
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_busy", (W+1)'(busy), '0);
    check("rst_done", (W+1)'(done), '0);
    check("rst_d", d, '0);
    rst_n = 1;
    @(negedge clk);
    issue(4'd9, 4'd3, 1'b1);
    wait_done("9m3", 5'b0_0110, 4);
    @(negedge clk);
    check("done_one_cycle", (W+1)'(done), '0);
    issue(4'd3, 4'd9, 1'b1);
    wait_done("3m9", 5'b1_1010, 4);
    @(negedge clk);
    issue(4'd15, 4'd15, 1'b1);
    wait_done("15m15", 5'b0_0000, 4);
    repeat (2) @(negedge clk);
    issue(4'd9, 4'd3, 1'b1);
    start = 1; a = 4'd1; b = 4'd0;
    @(negedge clk);
    start = 0;
    wait_done("ignore_start", 5'b0_0110, 0);
    @(negedge clk);
    issue(4'd9, 4'd3, 1'b1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("midrst_busy", (W+1)'(busy), '0);
    check("midrst_done", (W+1)'(done), '0);
    check("midrst_d", d, '0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_done", (W+1)'(done), '0);
    end
    issue(4'd5, 4'd2, 1'b1);
    wait_done("after_rst", 5'b0_0011, 4);
    @(negedge clk);
    issue(4'd9, 4'd3, 1'b1);
    wait_done("b2b_first", 5'b0_0110, 0);
    issue(4'd8, 4'd1, 1'b1);
    check("b2b_no_idle", (W+1)'(busy), (W+1)'(1));
    wait_done("b2b_second", 5'b0_0111, 4);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    @(negedge clk);
    issue(4'd15, 4'd1, 1'b0);
    wait_done("add_15p1", 5'b1_0000, 4);
    @(negedge clk);
    issue(4'd0, 4'd1, 1'b1);
    wait_done("sub_0m1", 5'b1_1111, 4);
`endif
    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
